bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Sequential controller for the shared 8-bit tri-state bus between two sources and two destinations. Channel 0 routes `data_in1` to `data_out1` and channel 1 routes `data_in2` to `data_out2`. The block arbitrates requests round-robin and drives the bus buffer enables with turnaround cycles, so the bus is never driven by two buffers at once. It also registers each transferred beat into per-channel output registers with a valid strobe.

## Interface
Parameters:
- `WIDTH`, 8: bus data width.
- `MAX_HOLD`, 16: maximum beats per grant; used only with the timeout feature; legal range 2–255.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  2  per-channel bus request; held high for the whole transfer.
- `last`  in  2  per-channel final-beat marker; sampled only while that channel is granted in XFER.
- `data_in1`, `data_in2`  in  WIDTH  source data for channel 0 and channel 1.
- `gnt`  out  2  one-hot grant; high from GRANT through XFER.
- `select`  out  1  bus owner: 0 = channel 0, 1 = channel 1; holds its value outside a grant.
- `drv_en0`, `drv_en1`  out  1  source-side buffer enables; at most one high, and only in XFER.
- `data_out1`, `data_out2`  out  WIDTH  registered destination data.
- `valid1`, `valid2`  out  1  one-cycle strobe when the matching `data_out` updates.
- `timeout`  out  1  one-cycle pulse when a grant is revoked (feature-dependent).

## Operation
States: IDLE, GRANT, XFER, RELEASE.
- **IDLE**
  - No `req` asserted: stay in IDLE.
  - One `req` asserted: grant that channel.
  - Both asserted: grant the channel named by the priority pointer `ptr`.
  - On grant: latch `select`, then go to GRANT.
- **GRANT**: one cycle. `gnt` is asserted and both `drv_en` are low (bus settle). Go to XFER.
- **XFER**: `drv_en` of the owner is high. Every cycle, capture the owner's `data_in` into its `data_out` and pulse its `valid`.
  - Exit to RELEASE after the beat in which `last[owner]` is high.
  - Also exit to RELEASE if `req[owner]` drops; that cycle's beat is not captured.
- **RELEASE**: one turnaround cycle. All enables low, `gnt` = 0. Set `ptr` to the other channel, then go to IDLE.
- Fairness: a channel that requests again immediately still waits behind a pending request from the other channel.
- A request from the non-owner during a grant is ignored until IDLE; `req` is not latched.
- `last` of the non-owner is ignored.
- Reset mid-transfer: all enables drop asynchronously. State returns to IDLE, and the interrupted beat is lost.

## Timing
- Reset values:
  - state = IDLE, `ptr` = 0, `select` = 0.
  - `gnt`, `drv_en0`, `drv_en1`, `valid1`, `valid2`, `timeout` = 0.
  - `data_out1` = `data_out2` = 0.
- Latency, with `req` sampled high at edge n:
  - `gnt` high after edge n.
  - `drv_en` high after edge n+1.
  - First `data_out` and `valid` after edge n+2.
- One beat per cycle in XFER. A single-beat transfer (`last` on the first XFER cycle) occupies 4 cycles: IDLE, GRANT, XFER, RELEASE.
- Minimum gap between two grants is 2 cycles (RELEASE, then IDLE) with both enables low.
- All outputs are registered; no combinational path from input to output.

## Configuration
- Macro `BUS_ARB_TIMEOUT_EN`.
- **Defined**
  - An 8-bit beat counter clears on entry to XFER and increments each XFER beat.
  - When the beat count reaches `MAX_HOLD` without `last`, that beat is still captured. The state then goes to RELEASE and `timeout` pulses for one cycle, aligned with RELEASE.
  - `last` on the same beat takes precedence: no `timeout` pulse.
- **Undefined**
  - No counter is built; `timeout` is tied to 0.
  - A grant lasts until `last` or until `req` drops.

## Structure
- Shared package `bus_arb_pkg`:
  - state encoding constants: IDLE = 2'd0, GRANT = 2'd1, XFER = 2'd2, RELEASE = 2'd3.
  - channel constants `CH0` and `CH1`.
  - default `WIDTH`.
- One sub-module, `rr_pick2`: a combinational 2-input round-robin selector with inputs `req` and `ptr`, and outputs `any` and `winner`.
- The FSM, output registers and optional counter stay in `bus_arbiter`.

## Test plan
- **Single request**: `req` = 01, `data_in1` = 8'hA5, `last[0]` on the first beat. Required: `gnt` = 01 at n+1, `drv_en0` at n+2, `data_out1` = A5 with `valid1` at n+3, then the bus idle for 2 cycles.
- **Contention**: `req` = 11 from reset. Required: channel 0 granted first. After its `last`, channel 1 granted with `select` = 1, and `data_out2` takes the `data_in2` value 8'h3C.
- **Fairness**: channel 0 re-requests immediately while channel 1 is pending. Required: channel 1 wins next; grants alternate 0,1,0,1 over 4 transfers.
- **Request drop**: `req[1]` falls mid-XFER after 3 beats. Required: exactly 3 `valid2` strobes, then RELEASE and IDLE.
- **Timeout**, with `BUS_ARB_TIMEOUT_EN`, `MAX_HOLD` = 4, `last` never asserted: 4 beats captured, then `timeout` pulses once and the grant passes to the pending channel.
- **Async reset in XFER**: assert `reset` between edges. Required: `drv_en0` = `drv_en1` = 0 immediately, and all outputs at their reset values.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-channel bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    localparam int DEFAULT_WIDTH = 8;

    function automatic logic [1:0] ch_onehot(input logic ch);
        return (ch == CH1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant, buffer-enable and destination-data bundle of the bus arbiter.
interface bus_arbiter_if #(parameter int WIDTH = bus_arb_pkg::DEFAULT_WIDTH);

    // A channel holds req high for its whole transfer; gnt answers one cycle
    // later and stays up until RELEASE. Dropping req mid-transfer ends it.
    logic [1:0]           req;
    logic [1:0]           last;
    logic [WIDTH-1:0]     data_in1;
    logic [WIDTH-1:0]     data_in2;
    logic [1:0]           gnt;
    logic                 select;
    logic                 drv_en0;
    logic                 drv_en1;
    logic [WIDTH-1:0]     data_out1;
    logic [WIDTH-1:0]     data_out2;
    logic                 valid1;
    logic                 valid2;
    logic                 timeout;
    bus_arb_pkg::state_t  state_dbg;

    modport slave (
        input  req, last, data_in1, data_in2,
        output gnt, select, drv_en0, drv_en1, data_out1, data_out2,
               valid1, valid2, timeout, state_dbg
    );

    modport master (
        output req, last, data_in1, data_in2,
        input  gnt, select, drv_en0, drv_en1, data_out1, data_out2,
               valid1, valid2, timeout, state_dbg
    );

endinterface

// File: rtl/bus_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick: a lone requester always wins,
// a tie goes to the channel named by ptr.
module rr_pick2
    import bus_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       any,
    output logic       winner
);

    always_comb begin
        any    = |req;
        winner = CH0;
        if (req == 2'b11) begin
            winner = ptr;
        end else if (req[1]) begin
            winner = CH1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin controller for a shared tri-state bus with turnaround cycles.
// Define BUS_ARB_TIMEOUT_EN to revoke a grant after MAX_HOLD beats.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.slave  bus
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("bus_arbiter: MAX_HOLD must lie in 2..255");
    end

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             sel_q, sel_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       drv_q, drv_d;
    logic [1:0]       vld_q, vld_d;
    logic [WIDTH-1:0] dout1_q, dout1_d;
    logic [WIDTH-1:0] dout2_q, dout2_d;
    logic             pick_any, pick_winner;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       to_q, to_d;
`endif

    rr_pick2 u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .any    (pick_any),
        .winner (pick_winner)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        dout1_d = dout1_q;
        dout2_d = dout2_q;
        vld_d   = 2'b00;
`ifdef BUS_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    sel_d   = pick_winner;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                state_d = XFER;
`ifdef BUS_ARB_TIMEOUT_EN
                cnt_d   = 8'd0;
`endif
            end
            XFER: begin
                // A dropped request abandons the beat presented this cycle.
                if (!bus.req[sel_q]) begin
                    state_d = RELEASE;
                end else begin
                    if (sel_q == CH0) begin
                        dout1_d  = bus.data_in1;
                        vld_d[0] = 1'b1;
                    end else begin
                        dout2_d  = bus.data_in2;
                        vld_d[1] = 1'b1;
                    end
                    if (bus.last[sel_q]) begin
                        state_d = RELEASE;
                    end
`ifdef BUS_ARB_TIMEOUT_EN
                    else if (cnt_q == HOLD_LAST) begin
                        state_d = RELEASE;
                        to_d    = 1'b1;
                    end
                    cnt_d = cnt_q + 8'd1;
`endif
                end
            end
            RELEASE: begin
                ptr_d   = ~sel_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they align with it.
        gnt_d = (state_d == GRANT || state_d == XFER) ? ch_onehot(sel_d) : 2'b00;
        drv_d = (state_d == XFER) ? ch_onehot(sel_d) : 2'b00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= CH0;
            sel_q   <= CH0;
            gnt_q   <= 2'b00;
            drv_q   <= 2'b00;
            vld_q   <= 2'b00;
            dout1_q <= '0;
            dout2_q <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt_q   <= 8'd0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            drv_q   <= drv_d;
            vld_q   <= vld_d;
            dout1_q <= dout1_d;
            dout2_q <= dout2_d;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            to_q    <= to_d;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.select    = sel_q;
    assign bus.drv_en0   = drv_q[0];
    assign bus.drv_en1   = drv_q[1];
    assign bus.data_out1 = dout1_q;
    assign bus.data_out2 = dout2_q;
    assign bus.valid1    = vld_q[0];
    assign bus.valid2    = vld_q[1];
    assign bus.state_dbg = state_q;
`ifdef BUS_ARB_TIMEOUT_EN
    assign bus.timeout   = to_q;
`else
    assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: vector table, corner-case sequences,
// and randomized traffic against a transaction-level reference model.
module tb_bus_arbiter;
    import bus_arb_pkg::*;

    localparam int W        = 8;
    localparam int MAX_HOLD = 4;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   req   = 2'b00;
    logic [1:0]   last  = 2'b00;
    logic [W-1:0] din1  = '0;
    logic [W-1:0] din2  = '0;

    int n_cmp = 0;
    int n_err = 0;

    bus_arbiter_if #(.WIDTH(W)) bus_if ();

    assign bus_if.req      = req;
    assign bus_if.last     = last;
    assign bus_if.data_in1 = din1;
    assign bus_if.data_in2 = din2;

    bus_arbiter #(.WIDTH(W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    // scoreboard
    logic [23:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] dut_out();
        return {bus_if.gnt, bus_if.drv_en1, bus_if.drv_en0, bus_if.select,
                bus_if.valid2, bus_if.valid1, bus_if.timeout,
                bus_if.data_out1, bus_if.data_out2};
    endfunction

    // Reference model: who owns the bus, how many beats it has moved,
    // and whether we are in the turnaround after a grant.
    int           m_owner;   // -1: nobody holds the bus
    int           m_beats;   // -1: grant issued, bus still settling
    bit           m_release;
    logic         m_ptr, m_sel, m_to;
    logic [1:0]   m_vld;
    logic [W-1:0] m_d1, m_d2;

    task automatic model_reset();
        m_owner = -1; m_beats = 0; m_release = 0;
        m_ptr = 1'b0; m_sel = 1'b0; m_to = 1'b0; m_vld = 2'b00;
        m_d1 = '0; m_d2 = '0;
    endtask

    task automatic model_step();
        m_vld = 2'b00;
        m_to  = 1'b0;
        if (m_release) begin
            m_release = 0;
            m_ptr     = ~m_sel;
        end else if (m_owner < 0) begin
            if (req != 2'b00) begin
                m_owner = (req == 2'b11) ? int'(m_ptr) : (req[1] ? 1 : 0);
                m_sel   = (m_owner == 1);
                m_beats = -1;
            end
        end else if (m_beats < 0) begin
            m_beats = 0;
        end else if (!req[m_owner]) begin
            m_owner   = -1;
            m_release = 1;
        end else begin
            if (m_owner == 0) begin m_d1 = din1; m_vld[0] = 1'b1; end
            else              begin m_d2 = din2; m_vld[1] = 1'b1; end
            m_beats++;
            if (last[m_owner]) begin
                m_owner   = -1;
                m_release = 1;
            end
`ifdef BUS_ARB_TIMEOUT_EN
            else if (m_beats == MAX_HOLD) begin
                m_owner   = -1;
                m_release = 1;
                m_to      = 1'b1;
            end
`endif
        end
    endtask

    function automatic logic [23:0] model_out();
        logic [1:0] g, d;
        g = (m_owner < 0) ? 2'b00 : ((m_owner == 1) ? 2'b10 : 2'b01);
        d = (m_owner >= 0 && m_beats >= 0) ? g : 2'b00;
        return {g, d, m_sel, m_vld, m_to, m_d1, m_d2};
    endfunction

    task automatic wait_idle(input string name);
        int k = 0;
        while (bus_if.state_dbg != IDLE && k < 20) begin
            @(negedge clk);
            k++;
        end
        check(name, bus_if.state_dbg, IDLE);
        check({name, "_gnt"}, bus_if.gnt, 2'b00);
    endtask

    task automatic test_reset_values();
        @(negedge clk);
        check("rst_state", bus_if.state_dbg, IDLE);
        check("rst_outputs", dut_out(), 24'h0);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [1:0] req, last;
        logic [7:0] d1, d2;
        logic [1:0] gnt, drv;
        logic       sel;
        logic [1:0] vld;
        logic [7:0] o1, o2;
    } vec_t;

    task automatic test_table();
        vec_t tbl[13];
        // contention from reset: ch0 first, then ch1 with 3C
        tbl[0]  = '{2'b11, 2'b00, 8'h11, 8'h3C, 2'b01, 2'b00, 1'b0, 2'b00, 8'h00, 8'h00};
        tbl[1]  = '{2'b11, 2'b00, 8'h11, 8'h3C, 2'b01, 2'b01, 1'b0, 2'b00, 8'h00, 8'h00};
        tbl[2]  = '{2'b11, 2'b01, 8'h11, 8'h3C, 2'b00, 2'b00, 1'b0, 2'b01, 8'h11, 8'h00};
        tbl[3]  = '{2'b11, 2'b00, 8'h11, 8'h3C, 2'b00, 2'b00, 1'b0, 2'b00, 8'h11, 8'h00};
        tbl[4]  = '{2'b11, 2'b00, 8'h11, 8'h3C, 2'b10, 2'b00, 1'b1, 2'b00, 8'h11, 8'h00};
        tbl[5]  = '{2'b11, 2'b00, 8'h11, 8'h3C, 2'b10, 2'b10, 1'b1, 2'b00, 8'h11, 8'h00};
        tbl[6]  = '{2'b11, 2'b10, 8'h11, 8'h3C, 2'b00, 2'b00, 1'b1, 2'b10, 8'h11, 8'h3C};
        // single request, one-beat transfer of A5, then two idle cycles
        tbl[7]  = '{2'b01, 2'b00, 8'hA5, 8'h00, 2'b00, 2'b00, 1'b1, 2'b00, 8'h11, 8'h3C};
        tbl[8]  = '{2'b01, 2'b00, 8'hA5, 8'h00, 2'b01, 2'b00, 1'b0, 2'b00, 8'h11, 8'h3C};
        tbl[9]  = '{2'b01, 2'b01, 8'hA5, 8'h00, 2'b01, 2'b01, 1'b0, 2'b00, 8'h11, 8'h3C};
        tbl[10] = '{2'b01, 2'b01, 8'hA5, 8'h00, 2'b00, 2'b00, 1'b0, 2'b01, 8'hA5, 8'h3C};
        tbl[11] = '{2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 2'b00, 8'hA5, 8'h3C};
        tbl[12] = '{2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 2'b00, 8'hA5, 8'h3C};
        for (int i = 0; i < 13; i++) begin
            req = tbl[i].req; last = tbl[i].last; din1 = tbl[i].d1; din2 = tbl[i].d2;
            @(negedge clk);
            check($sformatf("vec%0d_gnt", i), bus_if.gnt, tbl[i].gnt);
            check($sformatf("vec%0d_drv", i), {bus_if.drv_en1, bus_if.drv_en0}, tbl[i].drv);
            check($sformatf("vec%0d_sel", i), bus_if.select, tbl[i].sel);
            check($sformatf("vec%0d_vld", i), {bus_if.valid2, bus_if.valid1}, tbl[i].vld);
            check($sformatf("vec%0d_out1", i), bus_if.data_out1, tbl[i].o1);
            check($sformatf("vec%0d_out2", i), bus_if.data_out2, tbl[i].o2);
        end
    endtask

    task automatic test_req_drop();
        int v2 = 0;
        req = 2'b10; last = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check("drop_drv_en1", bus_if.drv_en1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            din2 = 8'h41 + 8'(i);
            @(negedge clk);
            if (bus_if.valid2) v2++;
        end
        din2 = 8'h44;
        req  = 2'b00;
        @(negedge clk);
        check("drop_valid2_after", bus_if.valid2, 1'b0);
        check("drop_release", bus_if.state_dbg, RELEASE);
        check("drop_gnt", bus_if.gnt, 2'b00);
        check("drop_beats", v2, 3);
        check("drop_last_data", bus_if.data_out2, 8'h43);
        @(negedge clk);
        check("drop_idle", bus_if.state_dbg, IDLE);
    endtask

    task automatic test_fairness();
        int owners[4] = '{9, 9, 9, 9};
        int got = 0;
        logic [1:0] prev;
        req = 2'b11; last = 2'b11; din1 = 8'h5A; din2 = 8'hC3;
        prev = bus_if.gnt;
        for (int k = 0; k < 40 && got < 4; k++) begin
            @(negedge clk);
            if (bus_if.gnt != 2'b00 && prev == 2'b00) begin
                owners[got] = int'(bus_if.gnt[1]);
                got++;
            end
            prev = bus_if.gnt;
        end
        check("fair_grants", got, 4);
        for (int k = 0; k < 4; k++) check($sformatf("fair_owner%0d", k), owners[k], k % 2);
        req = 2'b00; last = 2'b00;
        wait_idle("fair_idle");
    endtask

`ifdef BUS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int owners[2] = '{9, 9};
        int got = 0, v1 = 0, to = 0, v1_at_to = -1;
        logic [1:0] st_at_to = 2'b00;
        logic [1:0] prev;
        req = 2'b11; last = 2'b00; din1 = 8'h77; din2 = 8'h88;
        prev = bus_if.gnt;
        for (int k = 0; k < 40 && got < 2; k++) begin
            @(negedge clk);
            if (bus_if.valid1) v1++;
            if (bus_if.timeout) begin
                to++;
                v1_at_to = v1;
                st_at_to = bus_if.state_dbg;
            end
            if (bus_if.gnt != 2'b00 && prev == 2'b00) begin
                owners[got] = int'(bus_if.gnt[1]);
                got++;
            end
            prev = bus_if.gnt;
        end
        req = 2'b00;
        check("to_grants", got, 2);
        check("to_first_owner", owners[0], 0);
        check("to_second_owner", owners[1], 1);
        check("to_beats", v1, MAX_HOLD);
        check("to_pulses", to, 1);
        check("to_beats_at_pulse", v1_at_to, MAX_HOLD);
        check("to_state_at_pulse", st_at_to, RELEASE);
        check("to_data", bus_if.data_out1, 8'h77);
        wait_idle("to_idle");
    endtask
`else
    task automatic test_timeout();
        int v1 = 0, to = 0;
        req = 2'b01; last = 2'b00; din1 = 8'h77;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus_if.valid1) v1++;
            if (bus_if.timeout) to++;
        end
        check("hold_gnt", bus_if.gnt, 2'b01);
        check("hold_beats", v1, 18);
        check("hold_no_timeout", to, 0);
        req = 2'b00;
        wait_idle("hold_idle");
    endtask
`endif

    task automatic test_async_reset();
        req = 2'b01; last = 2'b00; din1 = 8'h99;
        @(negedge clk);
        @(negedge clk);
        check("arst_pre_drv_en0", bus_if.drv_en0, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("arst_drv_en0", bus_if.drv_en0, 1'b0);
        check("arst_drv_en1", bus_if.drv_en1, 1'b0);
        check("arst_outputs", dut_out(), 24'h0);
        check("arst_state", bus_if.state_dbg, IDLE);
        @(negedge clk);
        reset = 1'b0;
        req   = 2'b00;
    endtask

    task automatic test_random();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (!req[c]) req[c] = ($urandom_range(0, 2) == 0);
                else         req[c] = ($urandom_range(0, 19) != 0);
                last[c] = ($urandom_range(0, 3) == 0);
            end
            din1 = W'($urandom);
            din2 = W'($urandom);
            @(posedge clk);
            model_step();
            exp_q.push_back(model_out());
            @(negedge clk);
            check($sformatf("rand_cycle%0d", i), dut_out(), exp_q.pop_front());
        end
        req = 2'b00;
    endtask

    initial begin
        test_reset_values();
        test_table();
        test_req_drop();
        test_fairness();
        test_timeout();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
